// File: rtl/fc_pkg.sv
// fc_pkg -- shared constants and FSM state encoding for the FC scheduler.
//   IN_BEATS : 3-channel feature beats per frame (48 features)
//   OUT_NUM  : output neurons issued per frame
//   DP_LAT   : datapath latency, dp_fire to dp_res_valid
//   DW       : signed result width
package fc_pkg;

   localparam int unsigned IN_BEATS = 16;
   localparam int unsigned OUT_NUM  = 10;
   localparam int unsigned DP_LAT   = 9;
   localparam int unsigned DW       = 12;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

endpackage

// File: rtl/fc_argmax.sv
// fc_argmax -- running signed argmax over a stream of neuron results.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear score/index back to zero (end of frame)
//   init_i   : first result of a frame, loaded unconditionally
//   upd_i    : later result, replaces the max only if strictly greater
//   data_i   : signed result value
//   idx_i    : neuron index of data_i
//   score_o  : current maximum score
//   index_o  : neuron index of current maximum
module fc_argmax #(
   parameter int unsigned DW = fc_pkg::DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 init_i,
   input  logic                 upd_i,
   input  logic signed [DW-1:0] data_i,
   input  logic [3:0]           idx_i,
   output logic signed [DW-1:0] score_o,
   output logic [3:0]           index_o
);

   logic signed [DW-1:0] score_q, score_d;
   logic [3:0]           index_q, index_d;

   always_comb begin
      score_d = score_q;
      index_d = index_q;
      if (clr_i) begin
         score_d = '0;
         index_d = '0;
      end else if (init_i) begin
         score_d = data_i;
         index_d = idx_i;
      end else if (upd_i && (data_i > score_q)) begin
         // strict compare: ties keep the earlier (lower) index
         score_d = data_i;
         index_d = idx_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_q <= '0;
         index_q <= '0;
      end else begin
         score_q <= score_d;
         index_q <= index_d;
      end
   end

   assign score_o = score_q;
   assign index_o = index_q;

endmodule

// File: rtl/fc_scheduler.sv
// fc_scheduler -- sequences one fully-connected layer frame:
// load IN_BEATS feature beats, fire OUT_NUM neuron computations,
// collect results with a running argmax, then report the class.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream feature beat handshake
//   dp_load, dp_load_idx  : datapath buffer write strobe and beat index
//   dp_fire, dp_out_idx   : start one neuron computation and its index
//   dp_res_valid/_data    : datapath result strobe and signed value
//   cls_valid / cls_ready : classification handshake
//   cls_idx, cls_score    : argmax neuron index and its score
//   err                   : sticky protocol error (spurious result, watchdog)
module fc_scheduler #(
   parameter int unsigned IN_BEATS = fc_pkg::IN_BEATS,
   parameter int unsigned OUT_NUM  = fc_pkg::OUT_NUM,
   parameter int unsigned DP_LAT   = fc_pkg::DP_LAT,
   parameter int unsigned DW       = fc_pkg::DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 dp_load,
   output logic [3:0]           dp_load_idx,
   output logic                 dp_fire,
   output logic [3:0]           dp_out_idx,
   input  logic                 dp_res_valid,
   input  logic signed [DW-1:0] dp_res_data,
   output logic                 cls_valid,
   input  logic                 cls_ready,
   output logic [3:0]           cls_idx,
   output logic signed [DW-1:0] cls_score,
   output logic                 err
);

   import fc_pkg::*;

   localparam int unsigned WDW = $clog2(2*DP_LAT+1);

   state_e         state_q, state_d;
   logic [3:0]     beat_q, beat_d;
   logic [3:0]     oidx_q, oidx_d;
   logic [4:0]     outst_q, outst_d;
   logic [4:0]     res_q, res_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           err_q, err_d;

   logic res_acc, res_spur;
   logic am_clr, am_init, am_upd;

   assign in_ready    = (state_q == ST_LOAD);
   assign dp_load     = in_valid & in_ready;
   assign dp_fire     = (state_q == ST_ISSUE);
   assign cls_valid   = (state_q == ST_REPORT);
   assign dp_load_idx = beat_q;
   assign dp_out_idx  = oidx_q;
   assign err         = err_q;

   // A result with nothing outstanding is a protocol error and is dropped;
   // results are only collected while the frame is in flight.
   assign res_spur = dp_res_valid && (outst_q == '0);
   assign res_acc  = dp_res_valid && (outst_q != '0) &&
                     ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

   assign am_init = res_acc && (res_q == '0);
   assign am_upd  = res_acc && (res_q != '0);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      oidx_d  = oidx_q;
      outst_d = outst_q;
      res_d   = res_q;
      wd_d    = '0;
      err_d   = err_q | res_spur;
      am_clr  = 1'b0;

      if (dp_fire && !res_acc) begin
         outst_d = outst_q + 5'd1;
      end else if (!dp_fire && res_acc) begin
         outst_d = outst_q - 5'd1;
      end
      if (res_acc) begin
         res_d = res_q + 5'd1;
      end

      unique case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               if (beat_q == 4'(IN_BEATS-1)) begin
                  beat_d  = '0;
                  state_d = ST_ISSUE;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
         end
         ST_ISSUE: begin
            if (oidx_q == 4'(OUT_NUM-1)) begin
               oidx_d  = '0;
               state_d = ST_DRAIN;
            end else begin
               oidx_d = oidx_q + 4'd1;
            end
         end
         ST_DRAIN: begin
            if (res_acc) begin
               if (res_q == 5'(OUT_NUM-1)) begin
                  state_d = ST_REPORT;
               end
            end else if (wd_q == WDW'(2*DP_LAT-1)) begin
               // this is the 2*DP_LAT-th consecutive idle cycle
               err_d   = 1'b1;
               state_d = ST_REPORT;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         ST_REPORT: begin
            if (cls_ready) begin
               state_d = ST_LOAD;
               beat_d  = '0;
               oidx_d  = '0;
               outst_d = '0;
               res_d   = '0;
               am_clr  = 1'b1;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         beat_q  <= '0;
         oidx_q  <= '0;
         outst_q <= '0;
         res_q   <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         oidx_q  <= oidx_d;
         outst_q <= outst_d;
         res_q   <= res_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   fc_argmax #(
      .DW(DW)
   ) u_argmax (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (am_clr),
      .init_i  (am_init),
      .upd_i   (am_upd),
      .data_i  (dp_res_data),
      .idx_i   (res_q[3:0]),
      .score_o (cls_score),
      .index_o (cls_idx)
   );

endmodule

// File: tb/tb_fc_scheduler.sv
// tb_fc_scheduler -- scoreboard bench for fc_scheduler with a fixed-latency
// datapath model returning per-frame result tables.
module tb_fc_scheduler;

   localparam int IN_BEATS = 16;
   localparam int OUT_NUM  = 10;
   localparam int DP_LAT   = 9;
   localparam int DW       = 12;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic                 dp_load;
   logic [3:0]           dp_load_idx;
   logic                 dp_fire;
   logic [3:0]           dp_out_idx;
   logic                 dp_res_valid;
   logic signed [DW-1:0] dp_res_data;
   logic                 cls_valid;
   logic                 cls_ready;
   logic [3:0]           cls_idx;
   logic signed [DW-1:0] cls_score;
   logic                 err;

   fc_scheduler #(
      .IN_BEATS(IN_BEATS),
      .OUT_NUM (OUT_NUM),
      .DP_LAT  (DP_LAT),
      .DW      (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .dp_load      (dp_load),
      .dp_load_idx  (dp_load_idx),
      .dp_fire      (dp_fire),
      .dp_out_idx   (dp_out_idx),
      .dp_res_valid (dp_res_valid),
      .dp_res_data  (dp_res_data),
      .cls_valid    (cls_valid),
      .cls_ready    (cls_ready),
      .cls_idx      (cls_idx),
      .cls_score    (cls_score),
      .err          (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {int idx; int score; int err;} cls_t;
   typedef struct {int due; int data;} pend_t;

   int    exp_load[$];
   int    exp_fire[$];
   cls_t  exp_cls[$];
   pend_t pend[$];

   int cyc          = 0;
   int res_tab[10];
   bit drop_last    = 1'b0;
   bit spur_req     = 1'b0;
   int last_res_cyc = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event not expected/not seen (t=%0t)", name, $time);
   endtask

   // Datapath model: a fire sampled in cycle c returns its table entry in c+DP_LAT.
   initial begin : dp_model
      dp_res_valid = 1'b0;
      dp_res_data  = '0;
      forever begin
         @(negedge clk);
         if (dp_fire && !(drop_last && int'(dp_out_idx) == OUT_NUM-1))
            pend.push_back('{cyc + DP_LAT, res_tab[dp_out_idx]});
         @(posedge clk);
         cyc++;
         #1;
         if (spur_req) begin
            dp_res_valid = 1'b1;
            dp_res_data  = DW'(123);
         end else if (pend.size() > 0 && pend[0].due == cyc) begin
            dp_res_valid = 1'b1;
            dp_res_data  = DW'(pend[0].data);
            last_res_cyc = cyc;
            pend.delete(0);
         end else begin
            dp_res_valid = 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a load, fire or class.
   initial begin : monitor
      cls_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (dp_load) begin
               if (exp_load.size() == 0) fail_now("load_unexpected");
               else chk("load_idx", int'(dp_load_idx), exp_load.pop_front());
            end
            if (dp_fire) begin
               if (exp_fire.size() == 0) fail_now("fire_unexpected");
               else chk("fire_idx", int'(dp_out_idx), exp_fire.pop_front());
            end
            if (cls_valid && cls_ready) begin
               if (exp_cls.size() == 0) fail_now("cls_unexpected");
               else begin
                  e = exp_cls.pop_front();
                  chk("cls_idx",   int'(cls_idx), e.idx);
                  chk("cls_score", int'(cls_score), e.score);
                  chk("cls_err",   int'(err), e.err);
               end
            end
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"},    int'(in_ready), 1);
      chk({tag, "_dp_load"},     int'(dp_load), 0);
      chk({tag, "_dp_fire"},     int'(dp_fire), 0);
      chk({tag, "_dp_out_idx"},  int'(dp_out_idx), 0);
      chk({tag, "_dp_load_idx"}, int'(dp_load_idx), 0);
      chk({tag, "_cls_valid"},   int'(cls_valid), 0);
      chk({tag, "_cls_idx"},     int'(cls_idx), 0);
      chk({tag, "_cls_score"},   int'(cls_score), 0);
      chk({tag, "_err"},         int'(err), 0);
   endtask

   // Drives n beats back to back; a full frame also checks the issue window.
   task automatic send_frame(input int n, input bit hold_valid);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         exp_load.push_back(k);
      end
      if (n == IN_BEATS)
         for (int i = 0; i < OUT_NUM; i++) exp_fire.push_back(i);
      @(posedge clk);
      #1;
      in_valid = hold_valid;
      if (n == IN_BEATS) begin
         for (int i = 0; i < OUT_NUM; i++) begin
            @(negedge clk);
            chk("issue_fire", int'(dp_fire), 1);
            chk("issue_in_ready", int'(in_ready), 0);
         end
         @(negedge clk);
         chk("drain_no_fire", int'(dp_fire), 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_cls();
      int i = 0;
      @(negedge clk);
      while (!cls_valid && i < 200) begin
         @(negedge clk);
         i++;
      end
      if (!cls_valid) fail_now("cls_timeout");
   endtask

   initial begin : stimulus
      int err_cyc;
      int i;
      rst       = 1'b1;
      in_valid  = 1'b0;
      cls_ready = 1'b1;
      res_tab   = '{5, -3, 20, 7, 20, 1, 0, -8, 19, 2};
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset("rst0");

      // Frame A: tie at 20 keeps index 2; in_valid held high through ISSUE,
      // downstream stalls for 5 cycles.
      cls_ready = 1'b0;
      exp_cls.push_back('{2, 20, 0});
      send_frame(IN_BEATS, 1'b1);
      wait_cls();
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid",    int'(cls_valid), 1);
         chk("hold_idx",      int'(cls_idx), 2);
         chk("hold_score",    int'(cls_score), 20);
         chk("hold_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      cls_ready = 1'b1;
      @(posedge clk);
      #1;

      // Frame B: all negative, -4 first at index 1
      res_tab = '{-9, -4, -100, -50, -7, -4, -30, -12, -99, -4};
      exp_cls.push_back('{1, -4, 0});
      send_frame(IN_BEATS, 1'b0);
      wait_cls();
      @(posedge clk);
      #1;

      // Reset after beat 7 abandons the frame
      send_frame(8, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset("rst_mid");

      // Fresh frame after reset
      res_tab = '{5, -3, 20, 7, 20, 1, 0, -8, 19, 2};
      exp_cls.push_back('{2, 20, 0});
      send_frame(IN_BEATS, 1'b0);
      wait_cls();
      @(posedge clk);
      #1;

      // Last result dropped: watchdog fires after 18 idle drain cycles
      res_tab   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
      drop_last = 1'b1;
      exp_cls.push_back('{8, 9, 1});
      send_frame(IN_BEATS, 1'b0);
      err_cyc = -1;
      i = 0;
      while (!cls_valid && i < 200) begin
         @(negedge clk);
         if (err && err_cyc < 0) err_cyc = cyc;
         i++;
      end
      if (!cls_valid) fail_now("watchdog_timeout");
      chk("watchdog_err_cycle", err_cyc, last_res_cyc + 19);
      @(posedge clk);
      #1;
      drop_last = 1'b0;

      // Spurious result while idle in LOAD
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("spur_err_before", int'(err), 0);
      spur_req = 1'b1;
      @(posedge clk);
      #2;
      spur_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("spur_err_after", int'(err), 1);
      chk("spur_cls_valid", int'(cls_valid), 0);
      chk("spur_in_ready",  int'(in_ready), 1);

      repeat (3) @(negedge clk);
      chk("exp_load_left", exp_load.size(), 0);
      chk("exp_fire_left", exp_fire.size(), 0);
      chk("exp_cls_left",  exp_cls.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : global_timeout
      #200000;
      failures++;
      $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fc_scheduler.md
FC_SCHEDULER -- requirements
Module: fc_scheduler

Interface
REQ-001 Parameter IN_BEATS, default 16, is the number of 3-channel input beats per frame (48 features).
REQ-002 Parameter OUT_NUM, default 10, is the number of output neurons issued per frame.
REQ-003 Parameter DP_LAT, default 9, is the datapath latency in cycles from dp_fire to the matching dp_res_valid.
REQ-004 Parameter DW, default 12, is the result data width.
REQ-005 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  upstream feature beat valid.
REQ-009 in_ready  out  1  block accepts a beat.
REQ-010 dp_load  out  1  datapath buffer write strobe, equal to in_valid & in_ready.
REQ-011 dp_load_idx  out  4  beat index 0..IN_BEATS-1 for the current load.
REQ-012 dp_fire  out  1  start one neuron computation.
REQ-013 dp_out_idx  out  4  neuron index accompanying dp_fire.
REQ-014 dp_res_valid  in  1  datapath result strobe.
REQ-015 dp_res_data  in  DW  signed neuron result.
REQ-016 cls_valid  out  1  classification available.
REQ-017 cls_ready  in  1  downstream accepts the classification.
REQ-018 cls_idx  out  4  argmax neuron index.
REQ-019 cls_score  out  DW  signed maximum score.
REQ-020 err  out  1  sticky protocol error flag.

Function
REQ-021 The FSM SHALL have the states LOAD, ISSUE, DRAIN and REPORT, and SHALL enter LOAD on reset.
REQ-022 In LOAD, in_ready=1; each accepted beat SHALL pulse dp_load with dp_load_idx equal to the beat count; the beat that brings the count to IN_BEATS-1 SHALL move the FSM to ISSUE.
REQ-023 In ISSUE, dp_fire SHALL be 1 on every cycle, with dp_out_idx stepping 0..OUT_NUM-1 (exactly OUT_NUM consecutive cycles), and in_ready SHALL be 0; after the last index the FSM SHALL move to DRAIN.
REQ-024 Outstanding count SHALL increment on dp_fire and decrement on dp_res_valid; when both occur in the same cycle the count SHALL be unchanged.
REQ-025 Results SHALL be accepted in ISSUE and DRAIN (they overlap ISSUE when DP_LAT<OUT_NUM); the k-th result belongs to neuron k.
REQ-026 Argmax: comparison is signed; the first result initialises max and index; a later result replaces them only if strictly greater, so ties keep the lower index.
REQ-027 When the OUT_NUM-th result is received, the FSM SHALL move to REPORT.
REQ-028 In REPORT, cls_valid=1 and cls_idx/cls_score SHALL hold stable until cls_valid & cls_ready; on that cycle the FSM SHALL return to LOAD with counters cleared.
REQ-029 A dp_res_valid while the outstanding count is 0 SHALL set err and the result SHALL be ignored.
REQ-030 Watchdog: if DRAIN sees no result for 2*DP_LAT consecutive cycles, the block SHALL set err and go to REPORT with the partial argmax.
REQ-031 in_valid outside LOAD SHALL have no effect; dp_load SHALL never assert outside LOAD.

Reset
REQ-032 Reset SHALL apply: state=LOAD, in_ready=1, dp_load=0, dp_fire=0, dp_out_idx=0, dp_load_idx=0, cls_valid=0, cls_idx=0, cls_score=0, err=0, all counters=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; results arriving after reset release SHALL set err per REQ-029.

Structure
REQ-034 Package fc_pkg SHALL hold IN_BEATS, OUT_NUM, DP_LAT, DW and the FSM state encoding.
REQ-035 The argmax logic SHALL be implemented as sub-module fc_argmax (init/update/score/index).

Verification
REQ-036 16 back-to-back beats -> dp_load_idx 0..15; dp_fire on the next 10 cycles with idx 0..9; in_ready=0 throughout issue.
REQ-037 Model with DP_LAT=9 returning results {5,-3,20,7,20,1,0,-8,19,2} -> cls_idx=2, cls_score=20 (tie kept at lower index).
REQ-038 All results negative {-9,-4,-100,...,-4} -> cls_idx=1, cls_score=-4.
REQ-039 cls_ready held low for 5 cycles -> cls_valid and outputs stable; in_ready=0 until the handshake completes.
REQ-040 Datapath drops the last result -> err=1 after 18 idle cycles in DRAIN, REPORT entered; a spurious dp_res_valid in LOAD -> err=1.
REQ-041 rst pulsed after beat 7 -> all outputs at reset values next cycle; a fresh 16-beat frame completes normally.
